// File: rtl/pmt_pack_pkg.sv
// Shared constants, field widths and FSM state type for the PMT encoder packer.
package pmt_pack_pkg;

  localparam int unsigned PosW  = 18;
  localparam int unsigned SeqW  = 12;
  localparam int unsigned CntW  = 16;
  localparam int unsigned WordW = 32;

  localparam logic [7:0] HeadTag = 8'hA5;
  localparam logic [7:0] TailTag = 8'h5A;
  localparam logic [1:0] TagW    = 2'b01;
  localparam logic [1:0] TagX    = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StHead,
    StSamp,
    StXw,
    StTail
  } state_e;

endpackage

// File: rtl/pmt_encode_pack_if.sv
// Valid/ready word bus from the packer to the uplink serializer FIFO.
interface pmt_encode_pack_if;
  import pmt_pack_pkg::*;

  logic [WordW-1:0] dout;
  logic             dout_vld;
  logic             dout_rdy;

  modport master (output dout, output dout_vld, input dout_rdy);
  modport slave  (input dout, input dout_vld, output dout_rdy);
endinterface

// File: rtl/pack_sample_fifo.sv
// First-word-fall-through sample FIFO; a pop frees a slot for a same-cycle write when full.
module pack_sample_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 36
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic             wr_ok, rd_ok;

  always_comb begin
    empty_o   = (wptr_q == rptr_q);
    full_o    = (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]) && (wptr_q[AddrW] != rptr_q[AddrW]);
    rd_ok     = rd_en_i && !empty_o;
    wr_ok     = wr_en_i && (!full_o || rd_ok);
    wptr_d    = wr_ok ? wptr_q + PtrOne : wptr_q;
    rptr_d    = rd_ok ? rptr_q + PtrOne : rptr_q;
    rd_data_o = mem_q[rptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_ok) mem_q[wptr_q[AddrW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/pmt_encode_pack.sv
// Frames the aligned W/X encoder stream into header / W,X pairs / tail words with
// decimation, overflow accounting and a registered valid/ready output.
module pmt_encode_pack
  import pmt_pack_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                scan_en_i,
  input  logic                encode_en_i,
  input  logic [PosW-1:0]     encode_w_i,
  input  logic [PosW-1:0]     encode_x_i,
  input  logic [CntW-1:0]     decim_i,
  output logic [CntW-1:0]     ovf_cnt_o,
  output logic                busy_o,
  pmt_encode_pack_if.master   dout_if
);

  state_e                state_q, state_d;
  logic                  scan_q, open_q, open_d, keep_q, keep_d;
  logic [CntW-1:0]       decim_q, decim_d, dcnt_q, dcnt_d;
  logic [2*PosW-1:0]     smp_q, smp_d;
  logic [SeqW-1:0]       seq_q, seq_d;
  logic [CntW-1:0]       scnt_q, scnt_d, ovf_cnt_q, ovf_cnt_d, fid_q, fid_d;
  logic                  ovf_flag_q, ovf_flag_d;
  logic [WordW-1:0]      dout_q, dout_d, word;
  logic                  vld_q, vld_d;
  logic                  scan_rise, scan_fall, frame_open, slot_free, load, pop, wr_en, drop;
  logic                  fifo_full, fifo_empty;
  logic [2*PosW-1:0]     fifo_rd;

  pack_sample_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (2 * PosW)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_data_i (smp_q),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    scan_rise  = scan_en_i & ~scan_q;
    scan_fall  = ~scan_en_i & scan_q;
    frame_open = (state_q == StIdle) && scan_rise;
    slot_free  = ~vld_q | dout_if.dout_rdy;

    open_d = open_q;
    if (frame_open)     open_d = 1'b1;
    else if (scan_fall) open_d = 1'b0;
    decim_d = frame_open ? decim_i : decim_q;

    // Decision stage; the chosen sample is written to the FIFO one cycle later.
    keep_d = 1'b0;
    dcnt_d = dcnt_q;
    if (frame_open) begin
      dcnt_d = '0;
    end else if (open_q && encode_en_i) begin
      if (dcnt_q == '0) begin
        keep_d = 1'b1;
        dcnt_d = decim_q;
      end else begin
        dcnt_d = dcnt_q - 16'd1;
      end
    end
    smp_d = keep_d ? {encode_w_i, encode_x_i} : smp_q;

    state_d = state_q;
    load    = 1'b0;
    word    = '0;
    pop     = 1'b0;
    fid_d   = fid_q;
    unique case (state_q)
      StIdle: if (frame_open) state_d = StHead;
      StHead: if (slot_free) begin
        load    = 1'b1;
        word    = {HeadTag, 8'h00, fid_q};
        state_d = StSamp;
      end
      StSamp: if (!fifo_empty) begin
        if (slot_free) begin
          load    = 1'b1;
          word    = {TagW, seq_q, fifo_rd[2*PosW-1:PosW]};
          state_d = StXw;
        end
      end else if (!open_q && !keep_q) begin
        state_d = StTail;
      end
      StXw: if (slot_free) begin
        load    = 1'b1;
        word    = {TagX, seq_q, fifo_rd[PosW-1:0]};
        pop     = 1'b1;
        state_d = StSamp;
      end
      StTail: if (slot_free) begin
        load    = 1'b1;
        word    = {TailTag, 7'd0, ovf_flag_q, scnt_q};
        fid_d   = fid_q + 16'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    wr_en = keep_q && (!fifo_full || pop);
    drop  = keep_q && fifo_full && !pop;

    // seq counts emitted pairs, which matches accepted samples since drops never reach the FIFO.
    seq_d = frame_open ? '0 : (pop ? seq_q + 12'd1 : seq_q);
    scnt_d = scnt_q;
    if (frame_open)                    scnt_d = '0;
    else if (wr_en && scnt_q != '1)    scnt_d = scnt_q + 16'd1;
    ovf_flag_d = frame_open ? 1'b0 : (ovf_flag_q | drop);
    ovf_cnt_d  = (drop && ovf_cnt_q != '1) ? ovf_cnt_q + 16'd1 : ovf_cnt_q;

    vld_d = vld_q;
    if (vld_q && dout_if.dout_rdy) vld_d = 1'b0;
    if (load)                      vld_d = 1'b1;
    dout_d = load ? word : dout_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      scan_q     <= 1'b0;
      open_q     <= 1'b0;
      keep_q     <= 1'b0;
      decim_q    <= '0;
      dcnt_q     <= '0;
      smp_q      <= '0;
      seq_q      <= '0;
      scnt_q     <= '0;
      ovf_flag_q <= 1'b0;
      ovf_cnt_q  <= '0;
      fid_q      <= '0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scan_q     <= scan_en_i;
      open_q     <= open_d;
      keep_q     <= keep_d;
      decim_q    <= decim_d;
      dcnt_q     <= dcnt_d;
      smp_q      <= smp_d;
      seq_q      <= seq_d;
      scnt_q     <= scnt_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_cnt_q  <= ovf_cnt_d;
      fid_q      <= fid_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
    end
  end

  assign dout_if.dout     = dout_q;
  assign dout_if.dout_vld = vld_q;
  assign busy_o           = (state_q != StIdle);
  assign ovf_cnt_o        = ovf_cnt_q;

endmodule
